spike_train_encoder: RTL and testbench

//   Multi-channel stochastic rate encoder. Turns per-channel frequency codes into one Bernoulli spike

---
 rtl/spike_train_encoder.sv | 190 +++++++++++++++++++
 tb/tb_spike_train_encoder.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_train_encoder.sv
// Multi-channel stochastic rate encoder.
// Each channel runs its own Galois LFSR. Once per timestep the channel's
// frequency code is turned into a Bernoulli spike.
// Mode 0 compares the top LFSR bits against the code (linear rate).
// Mode 1 is the legacy log-bucket encoding, which ANDs together every other LFSR bit.
// Spikes are presented through a valid/ready handshake.
// A saturating per-channel counter tallies the accepted spikes.
module spike_train_encoder #(
  parameter int                N_CH   = 4,
  parameter int                LFSR_W = 16,
  parameter int                FREQ_W = 8,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter int                CNT_W  = 12,
  localparam int               CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mode_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [FREQ_W-1:0] cfg_freq_i,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              step_i,
  output logic              busy_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N_CH-1:0]   spikes_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  cnt_out_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EVAL  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q       [N_CH];
  logic [FREQ_W-1:0] freq_q       [N_CH];
  logic [FREQ_W-1:0] freqSample_q [N_CH];
  logic              modeSample_q;
  logic [N_CH-1:0]   spikes_q;
  logic [N_CH-1:0]   spikeCalc;
  logic              outValid_q;
  logic [CNT_W-1:0]  cnt_q        [N_CH];
  logic              handshake;
  logic              seedReload;
  logic              stepAccept;

  // Per-channel seed: the base seed XOR the channel index.
  // A zero result is replaced by 1, because an all-zero LFSR would lock up.
  function automatic logic [LFSR_W-1:0] seedFor(input logic [LFSR_W-1:0] base, input int idx);
    logic [LFSR_W-1:0] s;
    s = base ^ LFSR_W'(idx);
    if (s == '0) s = {{(LFSR_W-1){1'b0}}, 1'b1};
    return s;
  endfunction

  // One Galois step: shift right, and fold the taps back in when the bit shifted out is 1.
  function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] r);
    return (r >> 1) ^ (r[0] ? TAPS : '0);
  endfunction

  // Map the 8-bit view of a frequency code to its legacy bucket depth k.
  function automatic logic [3:0] bucketK(input logic [7:0] f);
    logic [3:0] k;
    if (f >= 8'd193)     k = 4'd8;
    else if (f >= 8'd97) k = 4'd7;
    else if (f >= 8'd49) k = 4'd6;
    else if (f >= 8'd24) k = 4'd5;
    else                 k = 4'd0;
    return k;
  endfunction

  // AND of the k even-indexed LFSR bits. This gives a probability of 2^-k; k=0 never spikes.
  function automatic logic bucketAnd(input logic [LFSR_W-1:0] r, input logic [3:0] k);
    logic acc;
    acc = (k != 4'd0);
    for (int j = 0; j < 8; j++) begin
      if (j < int'(k)) acc = acc & r[2*j];
    end
    return acc;
  endfunction

  assign handshake  = (state_q == HOLD) && outValid_q && out_ready_i;
  assign seedReload = (state_q == IDLE) && seed_load_i;
  assign stepAccept = (state_q == IDLE) && !seed_load_i && step_i;

  // Timestep sequencer state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: a seed reload in IDLE swallows a coincident step
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (stepAccept) state_d = SHIFT;
      SHIFT:   state_d = EVAL;
      EVAL:    state_d = HOLD;
      HOLD:    if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LFSR bank: reseed or advance once per accepted step, only while idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_CH; i++) lfsr_q[i] <= seedFor(LFSR_W'(1), i);
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (seedReload)      lfsr_q[i] <= seedFor(seed_i, i);
        else if (stepAccept) lfsr_q[i] <= lfsrNext(lfsr_q[i]);
      end
    end
  end

  // Frequency registers accept writes in any state; out-of-range channels match nothing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_CH; i++) freq_q[i] <= '0;
    end else if (cfg_we_i) begin
      for (int i = 0; i < N_CH; i++) begin
        if (int'(cfg_ch_i) == i) freq_q[i] <= cfg_freq_i;
      end
    end
  end

  // Snapshot of codes and mode taken in SHIFT so later changes only affect the next step
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_CH; i++) freqSample_q[i] <= '0;
      modeSample_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      for (int i = 0; i < N_CH; i++) freqSample_q[i] <= freq_q[i];
      modeSample_q <= mode_i;
    end
  end

  // Per-channel spike decision from the current LFSR value and the sampled code
  always_comb begin
    spikeCalc = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (modeSample_q) spikeCalc[i] = bucketAnd(lfsr_q[i], bucketK(8'(freqSample_q[i])));
      else              spikeCalc[i] = (lfsr_q[i][LFSR_W-1 -: FREQ_W] < freqSample_q[i]);
    end
  end

  // Output register: capture in EVAL, hold through backpressure, drop valid on handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spikes_q   <= '0;
      outValid_q <= 1'b0;
    end else if (state_q == EVAL) begin
      spikes_q   <= spikeCalc;
      outValid_q <= 1'b1;
    end else if (handshake) begin
      outValid_q <= 1'b0;
    end
  end

  // Saturating spike counters; a clear beats an increment on the same edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_clr_i)
          cnt_q[i] <= '0;
        else if (handshake && spikes_q[i] && (cnt_q[i] != {CNT_W{1'b1}}))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter readback mux; an out-of-range channel reads as zero
  always_comb begin
    cnt_out_o = '0;
    if (int'(cfg_ch_i) < N_CH) cnt_out_o = cnt_q[cfg_ch_i];
  end

  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = outValid_q;
  assign spikes_o    = spikes_q;

endmodule

// File: tb/tb_spike_train_encoder.sv
// Directed bench for spike_train_encoder.
// A second instance with a 4-bit counter exercises saturation.
module tb_spike_train_encoder;

  logic        clk = 1'b0;
  logic        rstN;
  logic        mode;
  logic        cfgWe;
  logic [1:0]  cfgCh;
  logic [7:0]  cfgFreq;
  logic        seedLoad;
  logic [15:0] seed;
  logic        step;
  logic        outReady;
  logic        cntClr;

  logic        busy, outValid;
  logic [3:0]  spikes;
  logic [11:0] cntOut;
  logic        busyS, outValidS;
  logic [3:0]  spikesS;
  logic [3:0]  cntOutS;

  int testsRun     = 0;
  int testsFailed  = 0;
  int stepTimeouts = 0;

  logic [15:0] lfsrM [4];
  logic [7:0]  freqM [4];
  logic        modeM;

  spike_train_encoder dut (
    .clk_i(clk), .rst_ni(rstN), .mode_i(mode), .cfg_we_i(cfgWe), .cfg_ch_i(cfgCh),
    .cfg_freq_i(cfgFreq), .seed_load_i(seedLoad), .seed_i(seed), .step_i(step),
    .busy_o(busy), .out_valid_o(outValid), .out_ready_i(outReady), .spikes_o(spikes),
    .cnt_clr_i(cntClr), .cnt_out_o(cntOut)
  );

  spike_train_encoder #(.CNT_W(4)) dutSmall (
    .clk_i(clk), .rst_ni(rstN), .mode_i(mode), .cfg_we_i(cfgWe), .cfg_ch_i(cfgCh),
    .cfg_freq_i(cfgFreq), .seed_load_i(seedLoad), .seed_i(seed), .step_i(step),
    .busy_o(busyS), .out_valid_o(outValidS), .out_ready_i(outReady), .spikes_o(spikesS),
    .cnt_clr_i(cntClr), .cnt_out_o(cntOutS)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] modelShift(input logic [15:0] r);
    logic [15:0] n;
    n = {1'b0, r[15:1]};
    if (r[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic int modelK(input logic [7:0] f);
    if (f > 8'd192) return 8;
    if (f > 8'd96)  return 7;
    if (f > 8'd48)  return 6;
    if (f > 8'd23)  return 5;
    return 0;
  endfunction

  function automatic logic [3:0] modelSpikes();
    logic [3:0] s;
    int k;
    logic b;
    s = '0;
    for (int c = 0; c < 4; c++) begin
      if (modeM) begin
        k = modelK(freqM[c]);
        b = (k > 0);
        for (int j = 0; j < k; j++) b = b & lfsrM[c][2*j];
      end else begin
        b = (lfsrM[c][15:8] < freqM[c]);
      end
      s[c] = b;
    end
    return s;
  endfunction

  task automatic modelSeed(input logic [15:0] base);
    logic [15:0] s;
    for (int c = 0; c < 4; c++) begin
      s = base ^ 16'(c);
      if (s == 16'h0000) s = 16'h0001;
      lfsrM[c] = s;
    end
  endtask

  task automatic setFreq(input int ch, input logic [7:0] f);
    @(negedge clk);
    cfgWe = 1'b1; cfgCh = 2'(ch); cfgFreq = f;
    @(negedge clk);
    cfgWe = 1'b0;
    freqM[ch] = f;
  endtask

  task automatic setMode(input logic m);
    mode  = m;
    modeM = m;
  endtask

  task automatic clearCounters();
    @(negedge clk);
    cntClr = 1'b1;
    @(negedge clk);
    cntClr = 1'b0;
  endtask

  task automatic readCnt(input int ch, output logic [11:0] c, output logic [3:0] cs);
    @(negedge clk);
    cfgCh = 2'(ch);
    #1;
    c  = cntOut;
    cs = cntOutS;
  endtask

  task automatic doStep(input logic clrAtHs, output logic [3:0] got, output logic [3:0] exp);
    int waitCnt;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int c = 0; c < 4; c++) lfsrM[c] = modelShift(lfsrM[c]);
    exp = modelSpikes();
    waitCnt = 0;
    while (outValid !== 1'b1 && waitCnt < 8) begin
      @(negedge clk);
      waitCnt++;
    end
    if (outValid !== 1'b1) stepTimeouts++;
    got = spikes;
    outReady = 1'b1;
    cntClr   = clrAtHs;
    @(negedge clk);
    outReady = 1'b0;
    cntClr   = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] c;
    logic [3:0]  cs;
    #1;
    testsRun++;
    if (outValid !== 1'b0 || spikes !== 4'b0000 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got valid=%b spikes=%b busy=%b, expected 0/0000/0",
               outValid, spikes, busy);
    end
    @(negedge clk);
    rstN = 1'b1;
    modelSeed(16'h0001);
    for (int ch = 0; ch < 4; ch++) begin
      readCnt(ch, c, cs);
      testsRun++;
      if (c !== 12'd0) begin
        testsFailed++;
        $display("[TB] FAIL reset_cnt ch%0d: got %0d expected 0", ch, c);
      end
    end
  endtask

  task automatic test_threshold_ff();
    logic [3:0]  got, exp;
    logic [11:0] c;
    logic [3:0]  cs;
    int          errs, ch0Count;
    logic [3:0]  firstGot, firstExp;
    setMode(1'b0);
    setFreq(0, 8'hFF);
    setFreq(1, 8'h80);
    setFreq(2, 8'h01);
    setFreq(3, 8'h00);
    doStep(1'b0, got, exp);
    @(negedge clk);
    seedLoad = 1'b1; seed = 16'h0001; step = 1'b1;
    @(negedge clk);
    seedLoad = 1'b0; step = 1'b0;
    modelSeed(16'h0001);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL seed_priority_busy: got %b expected 0", busy);
    end
    clearCounters();
    ch0Count = 0;
    doStep(1'b0, got, exp);
    ch0Count += 1;
    testsRun++;
    if (got !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL thresh_step1: got %b expected 0001", got);
    end
    doStep(1'b0, got, exp);
    ch0Count += 1;
    testsRun++;
    if (got !== 4'b0011) begin
      testsFailed++;
      $display("[TB] FAIL thresh_step2: got %b expected 0011", got);
    end
    errs = 0; firstGot = '0; firstExp = '0;
    for (int n = 0; n < 1498; n++) begin
      doStep(1'b0, got, exp);
      ch0Count += int'(exp[0]);
      if (got !== exp) begin
        if (errs == 0) begin firstGot = got; firstExp = exp; end
        errs++;
      end
    end
    testsRun++;
    if (errs !== 0) begin
      testsFailed++;
      $display("[TB] FAIL thresh_stream: %0d bad steps, first got %b expected %b", errs, firstGot, firstExp);
    end
    readCnt(0, c, cs);
    testsRun++;
    if (c !== 12'(ch0Count)) begin
      testsFailed++;
      $display("[TB] FAIL thresh_cnt ch0: got %0d expected %0d", c, ch0Count);
    end
    testsRun++;
    if (cs !== 4'd15) begin
      testsFailed++;
      $display("[TB] FAIL thresh_cnt_small ch0: got %0d expected 15", cs);
    end
  endtask

  task automatic test_zero_freq();
    logic [3:0]  got, exp;
    logic [11:0] c;
    logic [3:0]  cs;
    int          errs;
    for (int ch = 0; ch < 4; ch++) setFreq(ch, 8'h00);
    clearCounters();
    errs = 0;
    for (int n = 0; n < 1000; n++) begin
      setMode(1'(n % 2));
      doStep(1'b0, got, exp);
      if (got !== 4'b0000) errs++;
    end
    testsRun++;
    if (errs !== 0) begin
      testsFailed++;
      $display("[TB] FAIL zero_freq_spikes: %0d nonzero steps, expected 0", errs);
    end
    for (int ch = 0; ch < 4; ch++) begin
      readCnt(ch, c, cs);
      testsRun++;
      if (c !== 12'd0) begin
        testsFailed++;
        $display("[TB] FAIL zero_freq_cnt ch%0d: got %0d expected 0", ch, c);
      end
    end
    setMode(1'b0);
  endtask

  task automatic test_hold_backpressure();
    logic [3:0] exp;
    int         errs;
    for (int ch = 0; ch < 4; ch++) setFreq(ch, 8'hFF);
    setMode(1'b0);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int c = 0; c < 4; c++) lfsrM[c] = modelShift(lfsrM[c]);
    exp = modelSpikes();
    testsRun++;
    if (busy !== 1'b1 || outValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL hold_t0: got busy=%b valid=%b expected 1/0", busy, outValid);
    end
    @(negedge clk);
    testsRun++;
    if (outValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL hold_t1_valid: got %b expected 0", outValid);
    end
    mode = 1'b1;
    @(negedge clk);
    testsRun++;
    if (outValid !== 1'b1 || spikes !== exp) begin
      testsFailed++;
      $display("[TB] FAIL hold_t2: got valid=%b spikes=%b expected 1/%b", outValid, spikes, exp);
    end
    errs = 0;
    for (int n = 0; n < 5; n++) begin
      step = (n % 2 == 0);
      @(negedge clk);
      if (outValid !== 1'b1 || spikes !== exp || busy !== 1'b1) errs++;
    end
    step = 1'b0;
    testsRun++;
    if (errs !== 0) begin
      testsFailed++;
      $display("[TB] FAIL hold_stable: %0d unstable cycles, expected 0", errs);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    testsRun++;
    if (busy !== 1'b0 || outValid !== 1'b0 || spikes !== exp) begin
      testsFailed++;
      $display("[TB] FAIL hold_release: got busy=%b valid=%b spikes=%b expected 0/0/%b",
               busy, outValid, spikes, exp);
    end
    setMode(1'b0);
  endtask

  task automatic test_bucket_mode();
    logic [3:0] got, exp;
    int         errs, ch1Errs;
    logic [3:0] firstGot, firstExp;
    logic [7:0] bounds [8];
    setMode(1'b1);
    setFreq(0, 8'd30);
    setFreq(1, 8'd23);
    setFreq(2, 8'd100);
    setFreq(3, 8'd200);
    errs = 0; ch1Errs = 0; firstGot = '0; firstExp = '0;
    for (int n = 0; n < 5000; n++) begin
      doStep(1'b0, got, exp);
      if (got[1] !== 1'b0) ch1Errs++;
      if (got !== exp) begin
        if (errs == 0) begin firstGot = got; firstExp = exp; end
        errs++;
      end
    end
    testsRun++;
    if (errs !== 0) begin
      testsFailed++;
      $display("[TB] FAIL bucket_stream: %0d bad steps, first got %b expected %b", errs, firstGot, firstExp);
    end
    testsRun++;
    if (ch1Errs !== 0) begin
      testsFailed++;
      $display("[TB] FAIL bucket_freq23: %0d spikes, expected 0", ch1Errs);
    end
    bounds = '{8'd24, 8'd48, 8'd49, 8'd96, 8'd97, 8'd192, 8'd193, 8'd255};
    for (int g = 0; g < 2; g++) begin
      for (int ch = 0; ch < 4; ch++) setFreq(ch, bounds[g*4 + ch]);
      errs = 0; firstGot = '0; firstExp = '0;
      for (int n = 0; n < 300; n++) begin
        doStep(1'b0, got, exp);
        if (got !== exp) begin
          if (errs == 0) begin firstGot = got; firstExp = exp; end
          errs++;
        end
      end
      testsRun++;
      if (errs !== 0) begin
        testsFailed++;
        $display("[TB] FAIL bucket_bounds group%0d: %0d bad steps, first got %b expected %b",
                 g, errs, firstGot, firstExp);
      end
    end
    setMode(1'b0);
  endtask

  task automatic test_saturation();
    logic [3:0]  got, exp;
    logic [11:0] c;
    logic [3:0]  cs;
    int          cnt0, errs;
    setMode(1'b0);
    setFreq(0, 8'hFF);
    for (int ch = 1; ch < 4; ch++) setFreq(ch, 8'h00);
    clearCounters();
    cnt0 = 0; errs = 0;
    for (int n = 0; n < 40; n++) begin
      doStep(1'b0, got, exp);
      cnt0 += int'(exp[0]);
      if (got !== exp) errs++;
    end
    testsRun++;
    if (errs !== 0) begin
      testsFailed++;
      $display("[TB] FAIL sat_stream: %0d bad steps, expected 0", errs);
    end
    readCnt(0, c, cs);
    testsRun++;
    if (cs !== 4'((cnt0 > 15) ? 15 : cnt0)) begin
      testsFailed++;
      $display("[TB] FAIL sat_small ch0: got %0d expected %0d", cs, (cnt0 > 15) ? 15 : cnt0);
    end
    testsRun++;
    if (c !== 12'(cnt0)) begin
      testsFailed++;
      $display("[TB] FAIL sat_wide ch0: got %0d expected %0d", c, cnt0);
    end
    doStep(1'b1, got, exp);
    readCnt(0, c, cs);
    testsRun++;
    if (c !== 12'd0 || cs !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL clr_at_handshake ch0: got wide=%0d small=%0d expected 0/0", c, cs);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0]  got, exp;
    logic [11:0] c;
    logic [3:0]  cs;
    for (int ch = 0; ch < 4; ch++) setFreq(ch, 8'hFF);
    setMode(1'b0);
    clearCounters();
    doStep(1'b0, got, exp);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int k = 0; k < 4; k++) lfsrM[k] = modelShift(lfsrM[k]);
    exp = modelSpikes();
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (outValid !== 1'b1 || spikes !== exp) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset_hold: got valid=%b spikes=%b expected 1/%b", outValid, spikes, exp);
    end
    #2;
    rstN = 1'b0;
    #1;
    testsRun++;
    if (outValid !== 1'b0 || spikes !== 4'b0000 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got valid=%b spikes=%b busy=%b expected 0/0000/0",
               outValid, spikes, busy);
    end
    @(negedge clk);
    rstN = 1'b1;
    modelSeed(16'h0001);
    for (int ch = 0; ch < 4; ch++) freqM[ch] = 8'h00;
    readCnt(0, c, cs);
    testsRun++;
    if (c !== 12'd0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_cnt ch0: got %0d expected 0", c);
    end
    doStep(1'b0, got, exp);
    testsRun++;
    if (got !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_freq: got %b expected 0000", got);
    end
  endtask

  task automatic test_timeouts();
    testsRun++;
    if (stepTimeouts !== 0) begin
      testsFailed++;
      $display("[TB] FAIL step_timeouts: got %0d expected 0", stepTimeouts);
    end
  endtask

  initial begin
    rstN = 1'b0; mode = 1'b0; cfgWe = 1'b0; cfgCh = 2'd0; cfgFreq = 8'd0;
    seedLoad = 1'b0; seed = 16'd0; step = 1'b0; outReady = 1'b0; cntClr = 1'b0;
    modeM = 1'b0;
    for (int c = 0; c < 4; c++) freqM[c] = 8'h00;
    modelSeed(16'h0001);
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_threshold_ff();
    test_zero_freq();
    test_hold_backpressure();
    test_bucket_mode();
    test_saturation();
    test_async_reset();
    test_timeouts();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
